// File: rtl/fp_normalize_round_if.sv
// Handshake and payload bundle between the FP adder ALU stage, the normalize/round stage and its consumer.
// NORM_FLAGS_EN adds the {overflow, underflow, inexact} flags signal.
interface fp_normalize_round_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    signIn;
  logic [EXP_W-1:0]        exponentIn;
  logic                    carryIn;
  logic [FRAC_W:0]         mantissaIn;
  logic                    guardIn;
  logic                    roundIn;
  logic                    stickyIn;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   result;
`ifdef NORM_FLAGS_EN
  logic [2:0]              flags;

  modport master (
    output in_valid, signIn, exponentIn, carryIn, mantissaIn,
           guardIn, roundIn, stickyIn, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, signIn, exponentIn, carryIn, mantissaIn,
           guardIn, roundIn, stickyIn, out_ready,
    output in_ready, out_valid, result, flags
  );
`else
  modport master (
    output in_valid, signIn, exponentIn, carryIn, mantissaIn,
           guardIn, roundIn, stickyIn, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, signIn, exponentIn, carryIn, mantissaIn,
           guardIn, roundIn, stickyIn, out_ready,
    output in_ready, out_valid, result
  );
`endif
endinterface

// File: rtl/fp_normalize_round.sv
// Post-ALU stage of the FP adder: iterative one-bit-per-cycle normalization, round-to-nearest-even, IEEE pack.
// Optional macro NORM_FLAGS_EN enables the {overflow, underflow, inexact} flags output.
module fp_normalize_round #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input logic               clk,
  input logic               rst,
  fp_normalize_round_if.slave bus_if
);

  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned SUM_W  = MANT_W + 1;
  localparam int unsigned EXPX_W = EXP_W + 1;
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic                sign_q;
  logic [EXP_W-1:0]    exp_q;
  logic                carry_q;
  logic [MANT_W-1:0]   mant_q;
  logic                g_q;
  logic                r_q;
  logic                s_q;
  logic [RES_W-1:0]    result_q;
  logic                out_valid_q;
  logic                in_ready_q;
`ifdef NORM_FLAGS_EN
  logic [2:0]          flags_q;
`endif

  logic                round_up;
  logic [SUM_W-1:0]    mant_sum;
  logic [MANT_W-1:0]   mant_rnd;
  logic [EXPX_W-1:0]   exp_rnd;
  logic                rnd_inf;

  // Round-to-nearest-even on the normalized operand, with renormalization on mantissa overflow.
  always_comb begin
    round_up = g_q & (r_q | s_q | mant_q[0]);
    mant_sum = {1'b0, mant_q} + SUM_W'(round_up);
    mant_rnd = mant_sum[MANT_W-1:0];
    exp_rnd  = {1'b0, exp_q};
    if (mant_sum[MANT_W]) begin
      mant_rnd = mant_sum[MANT_W:1];
      exp_rnd  = exp_rnd + EXPX_W'(1);
    end
    rnd_inf = (exp_rnd >= {1'b0, EXP_ONES});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      carry_q     <= 1'b0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef NORM_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.in_valid) begin
            sign_q     <= bus_if.signIn;
            exp_q      <= bus_if.exponentIn;
            carry_q    <= bus_if.carryIn;
            mant_q     <= bus_if.mantissaIn;
            g_q        <= bus_if.guardIn;
            r_q        <= bus_if.roundIn;
            s_q        <= bus_if.stickyIn;
            in_ready_q <= 1'b0;
            if (bus_if.exponentIn == EXP_ONES) begin
              // Inf/NaN: payload passes straight through
              result_q    <= {bus_if.signIn, EXP_ONES, bus_if.mantissaIn[FRAC_W-1:0]};
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
`ifdef NORM_FLAGS_EN
              flags_q     <= '0;
`endif
            end else begin
              state_q <= ST_NORM;
            end
          end
        end

        ST_NORM: begin
          if (carry_q) begin
            {carry_q, mant_q, g_q, r_q} <= {1'b0, carry_q, mant_q, g_q};
            s_q     <= s_q | r_q;
            exp_q   <= exp_q + EXP_W'(1);
            state_q <= ST_ROUND;
          end else if (mant_q[MANT_W-1]) begin
            state_q <= ST_ROUND;
          end else if (~|{mant_q, g_q, r_q, s_q}) begin
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
`ifdef NORM_FLAGS_EN
            flags_q     <= '0;
`endif
          end else begin
            {mant_q, g_q, r_q} <= {mant_q[FRAC_W-1:0], g_q, r_q, 1'b0};
            exp_q <= exp_q - EXP_W'(1);
            // Exponent reaching zero flushes; the operand is known nonzero here
            if (exp_q == EXP_W'(1)) begin
              result_q    <= {sign_q, (RES_W-1)'(0)};
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
`ifdef NORM_FLAGS_EN
              flags_q     <= 3'b011;
`endif
            end
          end
        end

        ST_ROUND: begin
          mant_q <= mant_rnd;
          exp_q  <= exp_rnd[EXP_W-1:0];
          if (rnd_inf) begin
            result_q <= {sign_q, EXP_ONES, FRAC_W'(0)};
          end else begin
            result_q <= {sign_q, exp_rnd[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
          end
`ifdef NORM_FLAGS_EN
          flags_q <= {rnd_inf, 1'b0, g_q | r_q | s_q};
`endif
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end

        ST_DONE: begin
          if (bus_if.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.in_ready  = in_ready_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.result    = result_q;
`ifdef NORM_FLAGS_EN
  assign bus_if.flags     = flags_q;
`endif

endmodule
